// File: rtl/decode_issue_buffer.sv
// Two-wide in-order FIFO between decode and dual issue.
// Compacted pushes, in-order pops; flush empties the buffer.
package decode_issue_pkg;

    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] inst;
        logic        o_valid;
        logic        o_inst_lawful;
    } PC_set;

endpackage

module decode_issue_buffer
    import decode_issue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  PC_set                      in_pc0,
    input  PC_set                      in_pc1,
    output logic                       in_ready,
    output logic [1:0]                 out_valid,
    output PC_set                      out_pc0,
    output PC_set                      out_pc1,
    input  logic [1:0]                 out_pop,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] ONE = AW'(1);

    PC_set         mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic          wr_en0, wr_en1;
    PC_set         wr_data0;

    assign in_ready     = (count_q <= CW'(DEPTH - 2));
    assign out_valid[0] = (count_q >= CW'(1));
    assign out_valid[1] = (count_q >= CW'(2));
    assign out_pc0      = mem_q[rd_ptr_q];
    assign out_pc1      = mem_q[rd_ptr_q + ONE];
    assign count        = count_q;

    // A lone younger slot is compacted into the first free entry.
    always_comb begin
        push_n   = 2'd0;
        wr_en0   = 1'b0;
        wr_en1   = 1'b0;
        wr_data0 = in_pc0;
        if (in_ready && !flush) begin
            unique case (in_valid)
                2'b01: begin
                    push_n = 2'd1;
                    wr_en0 = 1'b1;
                end
                2'b10: begin
                    push_n   = 2'd1;
                    wr_en0   = 1'b1;
                    wr_data0 = in_pc1;
                end
                2'b11: begin
                    push_n = 2'd2;
                    wr_en0 = 1'b1;
                    wr_en1 = 1'b1;
                end
                default: push_n = 2'd0;
            endcase
        end
    end

    // Pop bits without a matching valid slot are masked; 2'b10 is ignored.
    always_comb begin
        pop_n = 2'd0;
        unique case (out_pop)
            2'b01: pop_n = out_valid[0] ? 2'd1 : 2'd0;
            2'b11: begin
                unique case (out_valid)
                    2'b11:   pop_n = 2'd2;
                    2'b01:   pop_n = 2'd1;
                    default: pop_n = 2'd0;
                endcase
            end
            default: pop_n = 2'd0;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(pop_n);
        wr_ptr_d = wr_ptr_q + AW'(push_n);
        count_d  = count_q + CW'(push_n) - CW'(pop_n);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone qualifies the outputs.
    always_ff @(posedge clk) begin
        if (wr_en0) begin
            mem_q[wr_ptr_q] <= wr_data0;
        end
        if (wr_en1) begin
            mem_q[wr_ptr_q + ONE] <= in_pc1;
        end
    end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Directed vector table plus hand sequences for decode_issue_buffer.
module tb_decode_issue_buffer;
    import decode_issue_pkg::*;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic [1:0] in_valid;
    PC_set      in_pc0;
    PC_set      in_pc1;
    logic       in_ready;
    logic [1:0] out_valid;
    PC_set      out_pc0;
    PC_set      out_pc1;
    logic [1:0] out_pop;
    logic [3:0] count;

    int checks;
    int failures;

    decode_issue_buffer #(.DEPTH(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc0    (in_pc0),
        .in_pc1    (in_pc1),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc0   (out_pc0),
        .out_pc1   (out_pc1),
        .out_pop   (out_pop),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [1:0]  iv;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [1:0]  pop;
        logic [3:0]  cnt;
        logic [1:0]  ov;
        logic        rdy;
        logic [31:0] h0;
        logic [31:0] h1;
    } vec_t;

    vec_t tbl [21];

    function automatic PC_set mkrec(input logic [31:0] pc);
        PC_set r;
        r.PC            = pc;
        r.inst          = ~pc ^ 32'h0000_0013;
        r.o_valid       = pc[2];
        r.o_inst_lawful = pc[3];
        return r;
    endfunction

    task automatic chk(input string name, input logic [66:0] act,
                       input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush    = 1'b0;
        in_valid = 2'b00;
        in_pc0   = '0;
        in_pc1   = '0;
        out_pop  = 2'b00;
    endtask

    task automatic step(input logic fl, input logic [1:0] iv,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] pop);
        flush    = fl;
        in_valid = iv;
        in_pc0   = mkrec(p0);
        in_pc1   = mkrec(p1);
        out_pop  = pop;
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic vec_t nv(input logic fl, input logic [1:0] iv,
        input logic [31:0] p0, input logic [31:0] p1,
        input logic [1:0] pop, input logic [3:0] cnt,
        input logic [1:0] ov, input logic rdy,
        input logic [31:0] h0, input logic [31:0] h1);
        vec_t v;
        v.fl = fl; v.iv = iv; v.p0 = p0; v.p1 = p1; v.pop = pop;
        v.cnt = cnt; v.ov = ov; v.rdy = rdy; v.h0 = h0; v.h1 = h1;
        return v;
    endfunction

    logic [31:0] exp_pc;

    initial begin
        checks   = 0;
        failures = 0;
        idle();

        // fill / overflow / drain
        tbl[0]  = nv(0, 2'b11, 32'h1c000000, 32'h1c000004, 2'b00,
                     4'd2, 2'b11, 1, 32'h1c000000, 32'h1c000004);
        tbl[1]  = nv(0, 2'b11, 32'h1c000008, 32'h1c00000c, 2'b00,
                     4'd4, 2'b11, 1, 32'h1c000000, 32'h1c000004);
        tbl[2]  = nv(0, 2'b11, 32'h1c000010, 32'h1c000014, 2'b00,
                     4'd6, 2'b11, 1, 32'h1c000000, 32'h1c000004);
        tbl[3]  = nv(0, 2'b11, 32'h1c000018, 32'h1c00001c, 2'b00,
                     4'd8, 2'b11, 0, 32'h1c000000, 32'h1c000004);
        tbl[4]  = nv(0, 2'b11, 32'h1c000020, 32'h1c000024, 2'b00,
                     4'd8, 2'b11, 0, 32'h1c000000, 32'h1c000004);
        tbl[5]  = nv(0, 2'b11, 32'h1c000028, 32'h1c00002c, 2'b11,
                     4'd6, 2'b11, 1, 32'h1c000008, 32'h1c00000c);
        tbl[6]  = nv(0, 2'b00, 32'h0, 32'h0, 2'b01,
                     4'd5, 2'b11, 1, 32'h1c00000c, 32'h1c000010);
        // flush beats same-cycle push and pop
        tbl[7]  = nv(1, 2'b11, 32'h1c000040, 32'h1c000044, 2'b11,
                     4'd0, 2'b00, 1, 32'h0, 32'h0);
        // compacted younger-only push, masked pops
        tbl[8]  = nv(0, 2'b10, 32'hdeadbee0, 32'h1c000010, 2'b00,
                     4'd1, 2'b01, 1, 32'h1c000010, 32'h0);
        tbl[9]  = nv(0, 2'b00, 32'h0, 32'h0, 2'b11,
                     4'd0, 2'b00, 1, 32'h0, 32'h0);
        tbl[10] = nv(0, 2'b00, 32'h0, 32'h0, 2'b11,
                     4'd0, 2'b00, 1, 32'h0, 32'h0);
        // count 7 blocks a 2-wide push
        tbl[11] = nv(0, 2'b11, 32'h1c0000a0, 32'h1c0000a4, 2'b00,
                     4'd2, 2'b11, 1, 32'h1c0000a0, 32'h1c0000a4);
        tbl[12] = nv(0, 2'b11, 32'h1c0000a8, 32'h1c0000ac, 2'b00,
                     4'd4, 2'b11, 1, 32'h1c0000a0, 32'h1c0000a4);
        tbl[13] = nv(0, 2'b11, 32'h1c0000b0, 32'h1c0000b4, 2'b00,
                     4'd6, 2'b11, 1, 32'h1c0000a0, 32'h1c0000a4);
        tbl[14] = nv(0, 2'b01, 32'h1c0000b8, 32'hdeadbee4, 2'b00,
                     4'd7, 2'b11, 0, 32'h1c0000a0, 32'h1c0000a4);
        tbl[15] = nv(0, 2'b11, 32'h1c0000c0, 32'h1c0000c4, 2'b01,
                     4'd6, 2'b11, 1, 32'h1c0000a4, 32'h1c0000a8);
        // out-of-order pop ignored, single-entry 11 pop
        tbl[16] = nv(0, 2'b00, 32'h0, 32'h0, 2'b11,
                     4'd4, 2'b11, 1, 32'h1c0000ac, 32'h1c0000b0);
        tbl[17] = nv(0, 2'b00, 32'h0, 32'h0, 2'b01,
                     4'd3, 2'b11, 1, 32'h1c0000b0, 32'h1c0000b4);
        tbl[18] = nv(0, 2'b00, 32'h0, 32'h0, 2'b10,
                     4'd3, 2'b11, 1, 32'h1c0000b0, 32'h1c0000b4);
        tbl[19] = nv(0, 2'b00, 32'h0, 32'h0, 2'b11,
                     4'd1, 2'b01, 1, 32'h1c0000b8, 32'h0);
        tbl[20] = nv(0, 2'b00, 32'h0, 32'h0, 2'b11,
                     4'd0, 2'b00, 1, 32'h0, 32'h0);

        rstn = 1'b0;
        #12;
        chk("reset_ov", 67'(out_valid), 67'(2'b00));
        chk("reset_cnt", 67'(count), 67'(0));
        chk("reset_rdy", 67'(in_ready), 67'(1));
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].p0, tbl[i].p1, tbl[i].pop);
            chk($sformatf("v%0d_cnt", i), 67'(count), 67'(tbl[i].cnt));
            chk($sformatf("v%0d_ov", i), 67'(out_valid), 67'(tbl[i].ov));
            chk($sformatf("v%0d_rdy", i), 67'(in_ready), 67'(tbl[i].rdy));
            if (tbl[i].ov[0])
                chk($sformatf("v%0d_pc0", i), out_pc0, mkrec(tbl[i].h0));
            if (tbl[i].ov[1])
                chk($sformatf("v%0d_pc1", i), out_pc1, mkrec(tbl[i].h1));
        end

        // steady 2-in/2-out streaming across several pointer wraps
        exp_pc = 32'h1c001000;
        step(0, 2'b11, exp_pc, exp_pc + 4, 2'b00);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("s%0d_cnt", c), 67'(count), 67'(2));
            chk($sformatf("s%0d_ov", c), 67'(out_valid), 67'(2'b11));
            chk($sformatf("s%0d_pc0", c), out_pc0, mkrec(exp_pc));
            chk($sformatf("s%0d_pc1", c), out_pc1, mkrec(exp_pc + 4));
            step(0, 2'b11, exp_pc + 8, exp_pc + 12, 2'b11);
            exp_pc = exp_pc + 8;
        end
        chk("s_end_pc0", out_pc0, mkrec(exp_pc));

        // asynchronous reset mid-stream
        step(0, 2'b11, 32'h1c002000, 32'h1c002004, 2'b00);
        chk("pre_rst_cnt", 67'(count), 67'(4));
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_ov", 67'(out_valid), 67'(2'b00));
        chk("arst_cnt", 67'(count), 67'(0));
        @(negedge clk);
        rstn = 1'b1;
        step(0, 2'b00, 32'h0, 32'h0, 2'b00);
        chk("post_rst_cnt", 67'(count), 67'(0));
        chk("post_rst_rdy", 67'(in_ready), 67'(1));
        step(0, 2'b01, 32'h1c003000, 32'h0, 2'b00);
        chk("post_rst_pc0", out_pc0, mkrec(32'h1c003000));
        chk("post_rst_ov", 67'(out_valid), 67'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
